// File: rtl/fifo_n.sv
// Purpose : parametrised DEPTH x WIDTH FIFO with ENA/RDY method handshakes (enq, deq, first, clear).
// Latency : one cycle enq-to-first; no bypass from enq_v to first.
// Backpr. : enq__RDY drops when full, deq__RDY/first__RDY drop when empty; strobes while not ready are ignored.
//
// Ports:
//   CLK, nRST                     clock (rising edge), synchronous active-low reset
//   enq__ENA, enq_v, enq__RDY     enqueue strobe, data, permission
//   deq__ENA, deq__RDY            dequeue strobe, permission (not empty)
//   first__RDY, first             head valid, head data
//   clear__ENA                    flush all entries (wins over enq/deq in the same cycle)
//   count                         occupancy 0..DEPTH
//
// Optional build macro FIFO_PIPELINE_FULL_EN: when defined, a full FIFO also accepts an
// enqueue in a cycle where deq__ENA is asserted (combinational deq__ENA -> enq__RDY path).

module fifo_n #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enq__ENA,
  input  logic [WIDTH-1:0] enq_v,
  output logic             enq__RDY,
  input  logic             deq__ENA,
  output logic             deq__RDY,
  output logic             first__RDY,
  output logic [WIDTH-1:0] first,
  input  logic             clear__ENA,
  output logic [CNTW-1:0]  count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] rp;
  logic [AW:0] wp;
  logic [AW:0] occ;

  logic empty;
  logic full;
  logic enq_ok;
  logic deq_ok;

  assign empty = (rp == wp);
  assign full  = (rp[AW-1:0] == wp[AW-1:0]) && (rp[AW] != wp[AW]);

`ifdef FIFO_PIPELINE_FULL_EN
  // A same-cycle dequeue frees the head slot, which is exactly the slot wp points at when full.
  assign enq__RDY = !full || deq__ENA;
`else
  assign enq__RDY = !full;
`endif

  assign deq__RDY   = !empty;
  assign first__RDY = !empty;
  assign first      = mem[rp[AW-1:0]];

  // Pointer difference is taken at pointer width so it wraps correctly, then resized.
  assign occ   = wp - rp;
  assign count = CNTW'(occ);

  assign enq_ok = enq__ENA && enq__RDY;
  assign deq_ok = deq__ENA && deq__RDY;

  always_ff @(posedge CLK) begin
    if (!nRST || clear__ENA) begin
      rp <= '0;
      wp <= '0;
    end else begin
      if (enq_ok) wp <= wp + PTR_ONE;
      if (deq_ok) rp <= rp + PTR_ONE;
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (nRST && !clear__ENA && enq_ok) begin
      mem[wp[AW-1:0]] <= enq_v;
    end
  end

  // Strobing a method while it is not ready is a protocol violation; it is ignored by the logic.
  a_enq_legal : assert property (@(posedge CLK) disable iff (!nRST) !(enq__ENA && !enq__RDY))
    else $warning("fifo_n: enq__ENA asserted while enq__RDY=0 (ignored)");
  a_deq_legal : assert property (@(posedge CLK) disable iff (!nRST) !(deq__ENA && !deq__RDY))
    else $warning("fifo_n: deq__ENA asserted while deq__RDY=0 (ignored)");

endmodule

// File: tb/tb_fifo_n.sv
// Purpose : randomized and directed stimulus for fifo_n, checked against a queue-based reference model.
// Latency : each step drives one clock cycle of strobes and compares outputs just after the edge.
// Backpr. : the model decides acceptance from its own occupancy, independent of the DUT's RDY outputs.

module tb_fifo_n;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH) + 1;
`ifdef FIFO_PIPELINE_FULL_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             enq__ENA = 1'b0;
  logic [WIDTH-1:0] enq_v = '0;
  logic             enq__RDY;
  logic             deq__ENA = 1'b0;
  logic             deq__RDY;
  logic             first__RDY;
  logic [WIDTH-1:0] first;
  logic             clear__ENA = 1'b0;
  logic [CNTW-1:0]  count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];   // reference contents, head at index 0
  logic [WIDTH-1:0] popped[$];

  fifo_n #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .enq__ENA   (enq__ENA),
    .enq_v      (enq_v),
    .enq__RDY   (enq__RDY),
    .deq__ENA   (deq__ENA),
    .deq__RDY   (deq__RDY),
    .first__RDY (first__RDY),
    .first      (first),
    .clear__ENA (clear__ENA),
    .count      (count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all registered outputs with the model while every strobe is idle.
  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".enq_rdy"}, 32'(enq__RDY), 32'(q.size() < DEPTH));
    chk({tag, ".deq_rdy"}, 32'(deq__RDY), 32'(q.size() != 0));
    chk({tag, ".first_rdy"}, 32'(first__RDY), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, ".first"}, first, q[0]);
  endtask

  // One clock cycle with the given strobes; the model applies the specified acceptance rules.
  task automatic cycle(input string tag, input logic e, input logic [WIDTH-1:0] v,
                       input logic d, input logic c);
    bit exp_erdy;
    bit deq_acc;
    bit enq_acc;
    enq__ENA = e; enq_v = v; deq__ENA = d; clear__ENA = c;
    #1;
    exp_erdy = (q.size() < DEPTH) || (PIPE && d);
    chk({tag, ".enq_rdy_now"}, 32'(enq__RDY), 32'(exp_erdy));
    deq_acc = d && (q.size() != 0);
    enq_acc = e && exp_erdy;
    if (c) begin
      q.delete();
    end else begin
      if (deq_acc) popped.push_back(q.pop_front());
      if (enq_acc) q.push_back(v);
    end
    @(posedge CLK);
    #1;
    enq__ENA = 1'b0; deq__ENA = 1'b0; clear__ENA = 1'b0;
    #1;
    check_state(tag);
  endtask

  task automatic do_reset(input int cycles);
    nRST = 1'b0;
    enq__ENA = 1'b0; deq__ENA = 1'b0; clear__ENA = 1'b0;
    repeat (cycles) @(posedge CLK);
    #1;
    nRST = 1'b1;
    q.delete();
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] fill_vals [4];
    fill_vals[0] = 32'h11; fill_vals[1] = 32'h22; fill_vals[2] = 32'h33; fill_vals[3] = 32'h44;

    // Reset then idle
    do_reset(2);
    check_state("reset");

    // Fill and drain
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, fill_vals[i], 1'b0, 1'b0);
    popped.delete();
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk("drain_order", popped[i], fill_vals[i]);

    // Streaming with wrap at count=2
    cycle("pre", 1'b1, 32'hA1, 1'b0, 1'b0);
    cycle("pre", 1'b1, 32'hA2, 1'b0, 1'b0);
    popped.delete();
    for (int i = 0; i < 10; i++) cycle("stream", 1'b1, 32'h100 + i, 1'b1, 1'b0);
    chk("stream_n", 32'(popped.size()), 32'd10);
    chk("stream_0", popped[0], 32'hA1);
    chk("stream_1", popped[1], 32'hA2);
    for (int i = 2; i < 10; i++) chk("stream_seq", popped[i], 32'h100 + i - 2);
    cycle("sdrain", 1'b0, '0, 1'b1, 1'b0);
    cycle("sdrain", 1'b0, '0, 1'b1, 1'b0);

    // Illegal strobes: enq while full, deq while empty
    for (int i = 0; i < 4; i++) cycle("fill2", 1'b1, fill_vals[i], 1'b0, 1'b0);
    cycle("enq_full", 1'b1, 32'hDEAD, 1'b0, 1'b0);
    popped.delete();
    for (int i = 0; i < 4; i++) cycle("drain2", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk("full_unchanged", popped[i], fill_vals[i]);
    cycle("deq_empty", 1'b0, '0, 1'b1, 1'b0);

    // Clear with a simultaneous enqueue
    for (int i = 0; i < 3; i++) cycle("fill3", 1'b1, fill_vals[i], 1'b0, 1'b0);
    cycle("clear", 1'b1, 32'h55, 1'b0, 1'b1);
    chk("clear_count", 32'(count), 32'd0);
    cycle("post_clear", 1'b1, 32'h66, 1'b0, 1'b0);
    chk("post_clear_first", first, 32'h66);
    cycle("post_clear_drain", 1'b0, '0, 1'b1, 1'b0);

    // Full with head 0x11, simultaneous deq+enq of 0x99 (outcome depends on build macro)
    for (int i = 0; i < 4; i++) cycle("fill4", 1'b1, fill_vals[i], 1'b0, 1'b0);
    cycle("full_deq_enq", 1'b1, 32'h99, 1'b1, 1'b0);
    chk("full_deq_enq_count", 32'(count), PIPE ? 32'd4 : 32'd3);
    chk("full_deq_enq_head", first, 32'h22);
    popped.delete();
    while (q.size() != 0) cycle("drain4", 1'b0, '0, 1'b1, 1'b0);
    if (PIPE) chk("pipe_4th", popped[3], 32'h99);
    else      chk("nopipe_n", 32'(popped.size()), 32'd3);

    // Reset mid-operation discards entries
    cycle("pre_rst", 1'b1, 32'h77, 1'b0, 1'b0);
    cycle("pre_rst", 1'b1, 32'h78, 1'b0, 1'b0);
    do_reset(1);
    check_state("mid_reset");

    // Randomized legal traffic with occasional clear
    for (int n = 0; n < 400; n++) begin
      logic e;
      logic d;
      logic c;
      e = ($urandom_range(0, 99) < 60) && (q.size() < DEPTH || PIPE);
      d = ($urandom_range(0, 99) < 50) && (q.size() != 0);
      if (e && q.size() == DEPTH && !d) e = 1'b0;
      c = ($urandom_range(0, 99) < 3);
      cycle("rand", e, WIDTH'($urandom), d, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
